single_clk_ram_param: RTL and testbench

Parametrised successor to the divider's 2-bit lookup RAM: a single-clock simple-dual-port RAM with one write port and one read port. Adds per-lane write masking, selectable read-during-write semantics, an optional output register and read-valid tracking. A hardware clear sequencer reinitialises every word after reset or on request. Sits beside the Newton divider datapath as reciprocal-seed and scratch storage, stalled by the same global enable.

---
 rtl/single_clk_ram_param_pkg.sv | 19 +
 rtl/single_clk_ram_param_clear_fsm.sv | 66 ++++++
 rtl/single_clk_ram_param.sv | 124 ++++++++++++
 tb/tb_single_clk_ram_param.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/single_clk_ram_param_pkg.sv
// Shared definitions for the parametrised single-clock simple-dual-port RAM.
package single_clk_ram_param_pkg;

  // Same-address read-during-write behaviour.
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Clear sequencer states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Width of one write-mask lane.
  function automatic int unsigned lane_width(input int unsigned dw, input int unsigned lanes);
    return dw / lanes;
  endfunction

endpackage

// File: rtl/single_clk_ram_param_clear_fsm.sv
// Clear sequencer: walks every address once, writing INIT_VALUE, after reset
// or when a clear is requested from idle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | memory usable, user ports live, waits for clr_req_i
//   ST_CLEAR | writes INIT_VALUE to mem[cnt], cnt++ per enabled cycle;
//            | leaves after the cycle that writes the last address
module ram_clear_fsm
  import single_clk_ram_param_pkg::*;
#(
  parameter int unsigned              ADDR_WIDTH = 7,
  parameter int unsigned              DATA_WIDTH = 2,
  parameter logic [DATA_WIDTH-1:0]    INIT_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  enable_i,
  input  logic                  clr_req_i,
  output logic                  busy_o,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o,
  output logic [DATA_WIDTH-1:0] clr_data_o
);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // State and address counter registers; reset starts a fresh clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a stalled cycle holds everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (enable_i) begin
      case (state_q)
        ST_CLEAR: begin
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (clr_req_i) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q == ST_CLEAR);
  assign clr_we_o   = busy_o & enable_i;
  assign clr_addr_o = cnt_q;
  assign clr_data_o = INIT_VALUE;

endmodule

// File: rtl/single_clk_ram_param.sv
// Single-clock simple-dual-port RAM with lane write masks, selectable
// read-during-write, optional output register and a hardware clear sequencer.
module single_clk_ram_param
  import single_clk_ram_param_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 2,
  parameter int unsigned           ADDR_WIDTH = 7,
  parameter int unsigned           LANES      = 1,
  parameter int                    RDW_MODE   = RDW_NEW,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  enable_i,
  input  logic                  we_i,
  input  logic [LANES-1:0]      wr_mask_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  clr_req_i,
  output logic                  busy_o
);

  localparam int unsigned LW    = lane_width(DATA_WIDTH, LANES);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  if (LW * LANES != DATA_WIDTH) begin : g_bad_lanes
    $error("DATA_WIDTH must be an integer multiple of LANES");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] clr_data;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  ram_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_clear (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .enable_i   (enable_i),
    .clr_req_i  (clr_req_i),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .clr_data_o (clr_data)
  );

  assign wr_acc = enable_i & we_i & ~busy;
  assign rd_acc = enable_i & rd_en_i & ~busy;

  // Word as it will look after the write: masked lanes new, others old.
  always_comb begin
    wr_merged = mem_q[wr_addr_i];
    for (int k = 0; k < int'(LANES); k++) begin
      if (wr_mask_i[k]) wr_merged[k*LW +: LW] = wr_data_i[k*LW +: LW];
    end
  end

  // Read word, bypassing the write merge on a same-address collision when new-data mode is selected.
  always_comb begin
    rd_word = mem_q[rd_addr_i];
    if ((RDW_MODE == RDW_NEW) && wr_acc && (wr_addr_i == rd_addr_i)) rd_word = wr_merged;
  end

  // Memory array; the clear sequencer owns the write port while busy.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem_q[clr_addr] <= clr_data;
    end else if (wr_acc) begin
      mem_q[wr_addr_i] <= wr_merged;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] rd_s1_q;
    logic                  rd_s1_v_q;

    // Two-stage read pipeline: capture stage then output stage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        rd_s1_q    <= '0;
        rd_s1_v_q  <= 1'b0;
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (enable_i) begin
        rd_s1_v_q  <= rd_acc;
        if (rd_acc) rd_s1_q <= rd_word;
        rd_valid_q <= rd_s1_v_q;
        if (rd_s1_v_q) rd_data_q <= rd_s1_q;
      end
    end
  end else begin : g_no_out_reg
    // Single-stage read: data lands one enabled cycle after acceptance.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (enable_i) begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= rd_word;
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = busy;

endmodule

// File: tb/tb_single_clk_ram_param.sv
// Directed bench for single_clk_ram_param: instance A uses the default
// 2-bit/128-word new-data configuration, instance B an 8-bit/16-word,
// two-lane, old-data, registered-output configuration.
module tb_single_clk_ram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Instance A signals
  logic       a_rst_n = 1'b0, a_en = 1'b1, a_we = 1'b0, a_re = 1'b0, a_clr = 1'b0;
  logic [0:0] a_mask = 1'b1;
  logic [6:0] a_waddr = '0, a_raddr = '0;
  logic [1:0] a_wdata = '0;
  logic [1:0] a_rdata;
  logic       a_rvalid, a_busy;

  // Instance B signals
  logic       b_rst_n = 1'b0, b_en = 1'b1, b_we = 1'b0, b_re = 1'b0, b_clr = 1'b0;
  logic [1:0] b_mask = 2'b11;
  logic [3:0] b_waddr = '0, b_raddr = '0;
  logic [7:0] b_wdata = '0;
  logic [7:0] b_rdata;
  logic       b_rvalid, b_busy;

  single_clk_ram_param #(
    .DATA_WIDTH(2), .ADDR_WIDTH(7), .LANES(1), .RDW_MODE(1), .OUT_REG(0), .INIT_VALUE(2'b00)
  ) dut_a (
    .clk_i(clk), .rst_n_i(a_rst_n), .enable_i(a_en), .we_i(a_we), .wr_mask_i(a_mask),
    .wr_addr_i(a_waddr), .wr_data_i(a_wdata), .rd_en_i(a_re), .rd_addr_i(a_raddr),
    .rd_data_o(a_rdata), .rd_valid_o(a_rvalid), .clr_req_i(a_clr), .busy_o(a_busy)
  );

  single_clk_ram_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .LANES(2), .RDW_MODE(0), .OUT_REG(1), .INIT_VALUE(8'h3C)
  ) dut_b (
    .clk_i(clk), .rst_n_i(b_rst_n), .enable_i(b_en), .we_i(b_we), .wr_mask_i(b_mask),
    .wr_addr_i(b_waddr), .wr_data_i(b_wdata), .rd_en_i(b_re), .rd_addr_i(b_raddr),
    .rd_data_o(b_rdata), .rd_valid_o(b_rvalid), .clr_req_i(b_clr), .busy_o(b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    int cnt;
    int bad_rv;

    // ---------------- Instance A: reset and initial clear ----------------
    step();
    chk("a_rst_busy", {31'd0, a_busy}, 32'd1);
    chk("a_rst_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("a_rst_rdata", {30'd0, a_rdata}, 32'd0);
    a_rst_n = 1'b1;
    cnt = 0;
    while (a_busy && cnt < 300) begin step(); cnt++; end
    chk("a_clear_len", cnt, 128);

    for (int i = 0; i < 128; i++) begin
      a_re = 1'b1; a_raddr = 7'(i);
      step();
      chk("a_init_rd", {29'd0, a_rvalid, a_rdata}, 32'b100);
    end
    a_re = 1'b0;

    // ---------------- Instance A: write then read, 1-cycle latency -------
    a_we = 1'b1; a_waddr = 7'd5; a_wdata = 2'b10; a_mask = 1'b1;
    step();
    a_we = 1'b0;
    step();
    chk("a_rv_idle", {31'd0, a_rvalid}, 32'd0);
    a_re = 1'b1; a_raddr = 7'd5;
    step();
    a_re = 1'b0;
    chk("a_rd5", {29'd0, a_rvalid, a_rdata}, {29'd0, 3'b110});
    step();
    chk("a_rd5_hold", {29'd0, a_rvalid, a_rdata}, {29'd0, 3'b010});

    // wr_mask=0 leaves the word untouched
    a_we = 1'b1; a_waddr = 7'd5; a_wdata = 2'b01; a_mask = 1'b0;
    step();
    a_we = 1'b0; a_mask = 1'b1; a_re = 1'b1; a_raddr = 7'd5;
    step();
    a_re = 1'b0;
    chk("a_mask0", {29'd0, a_rvalid, a_rdata}, {29'd0, 3'b110});

    // ---------------- Instance A: read-during-write, new data -----------
    a_we = 1'b1; a_waddr = 7'd9; a_wdata = 2'b01;
    step();
    a_wdata = 2'b11; a_re = 1'b1; a_raddr = 7'd9;
    step();
    chk("a_rdw_new", {29'd0, a_rvalid, a_rdata}, {29'd0, 3'b111});
    // different addresses do not interact
    a_waddr = 7'd10; a_wdata = 2'b01; a_raddr = 7'd9;
    step();
    a_we = 1'b0;
    chk("a_rdw_diff", {29'd0, a_rvalid, a_rdata}, {29'd0, 3'b111});
    a_raddr = 7'd10;
    step();
    chk("a_rd10", {29'd0, a_rvalid, a_rdata}, {29'd0, 3'b101});

    // ---------------- Instance A: stall after an accepted read ----------
    a_raddr = 7'd5;
    step();
    chk("a_rd5_b", {29'd0, a_rvalid, a_rdata}, {29'd0, 3'b110});
    a_en = 1'b0; a_raddr = 7'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("a_stall_rd", {29'd0, a_rvalid, a_rdata}, {29'd0, 3'b110});
    end
    a_en = 1'b1; a_re = 1'b0;
    step();
    chk("a_post_stall", {29'd0, a_rvalid, a_rdata}, {29'd0, 3'b010});

    // ---------------- Instance A: requested clear with blocked traffic --
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    chk("a_clr_busy", {31'd0, a_busy}, 32'd1);
    a_we = 1'b1; a_waddr = 7'd5; a_wdata = 2'b01; a_re = 1'b1; a_raddr = 7'd5;
    bad_rv = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (a_rvalid) bad_rv++;
    end
    a_clr = 1'b1;               // ignored while clearing
    step();
    a_clr = 1'b0;
    if (a_rvalid) bad_rv++;
    a_en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("a_clr_frozen", {31'd0, a_busy}, 32'd1);
    a_en = 1'b1;
    cnt = 0;
    while (a_busy && cnt < 300) begin
      step(); cnt++;
      if (a_rvalid) bad_rv++;
    end
    chk("a_clr_remaining", cnt, 87);
    chk("a_clr_no_rvalid", bad_rv, 0);
    a_we = 1'b0;
    a_raddr = 7'd5;
    step();
    a_re = 1'b0;
    chk("a_clr_rd5", {29'd0, a_rvalid, a_rdata}, {29'd0, 3'b100});

    // ---------------- Instance A: reset during a clear restarts it ------
    a_we = 1'b1; a_waddr = 7'd7; a_wdata = 2'b11;
    step();
    a_we = 1'b0; a_re = 1'b1; a_raddr = 7'd7;
    step();
    a_re = 1'b0;
    chk("a_rd7", {29'd0, a_rvalid, a_rdata}, {29'd0, 3'b111});
    step();
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    for (int i = 0; i < 60; i++) step();
    a_rst_n = 1'b0;
    #2;
    chk("a_midrst_busy", {31'd0, a_busy}, 32'd1);
    chk("a_midrst_rdata", {30'd0, a_rdata}, 32'd0);
    a_rst_n = 1'b1;
    cnt = 0;
    while (a_busy && cnt < 300) begin step(); cnt++; end
    chk("a_restart_len", cnt, 128);
    a_re = 1'b1; a_raddr = 7'd7;
    step();
    a_re = 1'b0;
    chk("a_rd7_cleared", {29'd0, a_rvalid, a_rdata}, {29'd0, 3'b100});

    // ---------------- Instance B: clear to INIT_VALUE -------------------
    b_rst_n = 1'b1;
    cnt = 0;
    while (b_busy && cnt < 100) begin step(); cnt++; end
    chk("b_clear_len", cnt, 16);
    b_re = 1'b1; b_raddr = 4'd3;
    step();
    b_re = 1'b0;
    chk("b_lat1_rvalid", {31'd0, b_rvalid}, 32'd0);
    step();
    chk("b_init_rd", {23'd0, b_rvalid, b_rdata}, {23'd0, 9'h13C});

    // ---------------- Instance B: lane masking --------------------------
    b_we = 1'b1; b_waddr = 4'd3; b_wdata = 8'hAA; b_mask = 2'b11;
    step();
    b_wdata = 8'h55; b_mask = 2'b01;
    step();
    b_we = 1'b0; b_re = 1'b1; b_raddr = 4'd3;
    step();
    b_re = 1'b0;
    step();
    chk("b_lane0", {23'd0, b_rvalid, b_rdata}, {23'd0, 9'h1A5});
    b_we = 1'b1; b_wdata = 8'h12; b_mask = 2'b10;
    step();
    b_we = 1'b0; b_re = 1'b1;
    step();
    b_re = 1'b0;
    step();
    chk("b_lane1", {23'd0, b_rvalid, b_rdata}, {23'd0, 9'h115});

    // ---------------- Instance B: read-during-write, old data -----------
    b_we = 1'b1; b_waddr = 4'd9; b_wdata = 8'h01; b_mask = 2'b11;
    step();
    b_wdata = 8'h03; b_re = 1'b1; b_raddr = 4'd9;
    step();
    b_we = 1'b0; b_re = 1'b0;
    step();
    chk("b_rdw_old", {23'd0, b_rvalid, b_rdata}, {23'd0, 9'h101});
    step();
    chk("b_rv_drop", {31'd0, b_rvalid}, 32'd0);

    // ---------------- Instance B: back-to-back pipelined reads ----------
    b_re = 1'b1; b_raddr = 4'd3;
    step();
    b_raddr = 4'd9;
    step();
    b_re = 1'b0;
    chk("b_b2b_first", {23'd0, b_rvalid, b_rdata}, {23'd0, 9'h115});
    step();
    chk("b_b2b_second", {23'd0, b_rvalid, b_rdata}, {23'd0, 9'h103});
    step();
    chk("b_b2b_end", {31'd0, b_rvalid}, 32'd0);

    // ---------------- Instance B: stall mid-read extends latency --------
    b_re = 1'b1; b_raddr = 4'd3;
    step();
    b_re = 1'b0; b_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b_stall_rd", {23'd0, b_rvalid, b_rdata}, {23'd0, 9'h003});
    end
    b_en = 1'b1;
    step();
    chk("b_stall_done", {23'd0, b_rvalid, b_rdata}, {23'd0, 9'h115});
    step();
    chk("b_stall_end", {31'd0, b_rvalid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
